// File: rtl/bip_data_memory.sv
// bip_data_memory: BIP CPU data RAM with one memory-mapped I/O word, power-on clear sequencer and sticky address-error flag
module bip_data_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR = 11'h7FF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Rd,
  input  logic                  Wr,
  input  logic [ADDR_WIDTH-1:0] DataAddr,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic [DATA_WIDTH-1:0] Out_Data,
  input  logic [DATA_WIDTH-1:0] Port_In,
  output logic [DATA_WIDTH-1:0] Port_Out,
  output logic                  Busy,
  output logic                  AddrErr
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] out_q, out_d, port_q, port_d;
  logic err_q, err_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic mapped, is_io, idle, rd, wr, mem_we;
  logic [PW-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  assign mapped = 32'(DataAddr) < DEPTH;
  assign is_io = DataAddr == IO_ADDR;
  assign idle = state_q == IDLE;
  assign rd = idle & Rd;
  assign wr = idle & Wr & ~Rd;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ptr_q <= '0;
      out_q <= '0;
      port_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      out_q <= out_d;
      port_q <= port_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = (state_q == CLEAR && ptr_q == PW'(DEPTH - 1)) ? IDLE : state_q;
    ptr_d = (state_q == CLEAR) ? ptr_q + 1'b1 : ptr_q;
  end
  always_comb begin
    out_d = rd ? (mapped ? mem[DataAddr[PW-1:0]] : is_io ? Port_In : '0) : out_q;
    port_d = (wr && is_io) ? In_Data : port_q;
    err_d = err_q | (idle & (Rd | Wr) & ~mapped & ~is_io);
    mem_we = ~Reset & ((state_q == CLEAR) | (wr & mapped));
    mem_addr = (state_q == CLEAR) ? ptr_q : DataAddr[PW-1:0];
    mem_wdata = (state_q == CLEAR) ? '0 : In_Data;
  end
  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign Out_Data = out_q;
  assign Port_Out = port_q;
  assign Busy = state_q == CLEAR;
  assign AddrErr = err_q;
endmodule

// File: tb/tb_bip_data_memory.sv
// tb_bip_data_memory: directed checks of RAM, I/O word, clear sequencer and address-error flag
module tb_bip_data_memory;
  logic clk = 1'b0;
  logic Reset = 1'b1, Rd = 1'b0, Wr = 1'b0;
  logic [10:0] DataAddr = '0;
  logic [15:0] In_Data = '0, Port_In = '0;
  logic [15:0] Out_Data, Port_Out;
  logic Busy, AddrErr;
  int n_pass = 0, n_total = 0;
  bip_data_memory dut (
    .Clock(clk), .Reset(Reset), .Rd(Rd), .Wr(Wr), .DataAddr(DataAddr),
    .In_Data(In_Data), .Out_Data(Out_Data), .Port_In(Port_In),
    .Port_Out(Port_Out), .Busy(Busy), .AddrErr(AddrErr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr_op(input logic [10:0] a, input logic [15:0] d);
    DataAddr = a; In_Data = d; Wr = 1'b1;
    cyc();
    Wr = 1'b0;
  endtask
  task automatic rd_op(input string tag, input logic [10:0] a, input logic [15:0] exp);
    DataAddr = a; Rd = 1'b1;
    cyc();
    Rd = 1'b0;
    chk(tag, 32'(Out_Data), 32'(exp));
  endtask
  task automatic wait_clear(input string tag);
    int n = 0;
    while (Busy === 1'b1 && n < 2000) begin
      cyc();
      n++;
    end
    chk(tag, n, 1024);
  endtask
  initial begin
    @(negedge clk);
    cyc();
    cyc();
    chk("rst_busy", 32'(Busy), 1);
    chk("rst_out", 32'(Out_Data), 0);
    chk("rst_port", 32'(Port_Out), 0);
    chk("rst_err", 32'(AddrErr), 0);
    Reset = 1'b0;
    wait_clear("clear_len");
    rd_op("clr_rd0", 11'd0, 16'h0);
    rd_op("clr_rd512", 11'd512, 16'h0);
    rd_op("clr_rd1023", 11'd1023, 16'h0);
    wr_op(11'd0, 16'd1);
    wr_op(11'd1, 16'd2);
    rd_op("rd0", 11'd0, 16'd1);
    rd_op("rd1", 11'd1, 16'd2);
    wr_op(11'd2, 16'd3);
    rd_op("rd2", 11'd2, 16'd3);
    DataAddr = 11'd0;
    cyc();
    cyc();
    chk("hold", 32'(Out_Data), 3);
    wr_op(11'd5, 16'hAAAA);
    DataAddr = 11'd5; In_Data = 16'h5555; Rd = 1'b1; Wr = 1'b1;
    cyc();
    Rd = 1'b0; Wr = 1'b0;
    chk("rdwr_out", 32'(Out_Data), 32'h0000AAAA);
    rd_op("rdwr_mem", 11'd5, 16'hAAAA);
    chk("rdwr_err", 32'(AddrErr), 0);
    Port_In = 16'h1234;
    rd_op("io_rd", 11'h7FF, 16'h1234);
    wr_op(11'h7FF, 16'h00FF);
    chk("io_port", 32'(Port_Out), 32'h00FF);
    rd_op("io_ram", 11'd1023, 16'h0);
    chk("io_err", 32'(AddrErr), 0);
    rd_op("pre_bad", 11'd0, 16'd1);
    wr_op(11'd1500, 16'd7);
    chk("bad_err", 32'(AddrErr), 1);
    rd_op("bad_rd", 11'd1500, 16'h0);
    rd_op("bad_alias", 11'd476, 16'h0);
    chk("bad_port", 32'(Port_Out), 32'h00FF);
    cyc();
    chk("bad_sticky", 32'(AddrErr), 1);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("r2_err", 32'(AddrErr), 0);
    chk("r2_port", 32'(Port_Out), 0);
    wr_op(11'h7FF, 16'hFFFF);
    rd_op("clr_ign_rd", 11'd1500, 16'h0);
    wr_op(11'd0, 16'd9);
    chk("clr_ign_port", 32'(Port_Out), 0);
    chk("clr_ign_err", 32'(AddrErr), 0);
    rd_op("clr_ign_rdio", 11'h7FF, 16'h0);
    for (int i = 0; i < 296; i++) cyc();
    chk("mid_busy", 32'(Busy), 1);
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    wait_clear("restart_len");
    rd_op("post_rd0", 11'd0, 16'h0);
    rd_op("post_rd5", 11'd5, 16'h0);
    chk("post_port", 32'(Port_Out), 0);
    chk("post_err", 32'(AddrErr), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
